// File: rtl/imm_encoder.sv
// imm_encoder: packs LOAD / STORE / BRANCH fields and a signed byte offset
// into a 32-bit RISC-V word. A 2-entry output FIFO decouples the sequencer
// from the instruction-memory writer.
// Optional feature macro: IMM_ENCODER_RANGE_CHECK_EN. When it is defined,
// offsets outside [-2048, 2047] are rejected instead of being truncated.
module imm_encoder #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int RISC_V_DATA_WIDTH = 32,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_kind,
    input  logic [4:0]                   req_rd,
    input  logic [4:0]                   req_rs1,
    input  logic [4:0]                   req_rs2,
    input  logic [2:0]                   req_funct3,
    input  logic [RISC_V_DATA_WIDTH-1:0] req_offset,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTRUCTION_WIDTH-1:0] out_instr,
    output logic                         err_pulse,
    output logic [CNT_WIDTH-1:0]         emit_count,
    output logic [CNT_WIDTH-1:0]         err_count
);

    localparam logic [1:0] KIND_LOAD   = 2'd0;
    localparam logic [1:0] KIND_STORE  = 2'd1;
    localparam logic [1:0] KIND_BRANCH = 2'd2;

    logic [11:0]                  imm;
    logic [31:0]                  word;
    logic                         in_range;
    logic                         legal;
    logic                         accept;
    logic                         push;
    logic                         pop;
    logic                         rdy_en;
    logic [1:0]                   fifo_count;
    logic [INSTRUCTION_WIDTH-1:0] tail;

    assign imm = req_offset[11:0];

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    // In range when every bit above the 12-bit field is a copy of bit 11.
    assign in_range = (&req_offset[RISC_V_DATA_WIDTH-1:11]) |
                      (~|req_offset[RISC_V_DATA_WIDTH-1:11]);
`else
    // Offset is silently truncated; the upper bits carry no meaning here.
    logic unused_offset_hi;
    assign unused_offset_hi = ^req_offset[RISC_V_DATA_WIDTH-1:12];
    assign in_range = 1'b1;
`endif

    assign legal  = (req_kind != 2'd3) && in_range;
    // rdy_en keeps req_ready low through reset and sets on the first edge after release.
    assign req_ready = rdy_en && (fifo_count < 2'd2);
    assign accept = req_valid && req_ready;
    assign push   = accept && legal;
    assign out_valid = (fifo_count != 2'd0);
    assign pop    = out_valid && out_ready;

    // Field packing for the three supported formats.
    always_comb begin
        word = '0;
        case (req_kind)
            KIND_LOAD:   word = {imm, req_rs1, req_funct3, req_rd, 7'b0000011};
            KIND_STORE:  word = {imm[11:5], req_rs2, req_rs1, req_funct3,
                                 imm[4:0], 7'b0100011};
            // Branch layout mirrors the decoder: no halfword shift.
            KIND_BRANCH: word = {imm[11], imm[9:4], req_rs2, req_rs1, req_funct3,
                                 imm[3:0], imm[10], 7'b1100011};
            default:     word = '0;
        endcase
    end

    // Ready enable: low in reset, high from the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    // Two-entry FIFO: out_instr is the head register, tail holds the second word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count <= 2'd0;
            out_instr  <= '0;
            tail       <= '0;
        end else begin
            case (fifo_count)
                2'd0: if (push) begin
                    out_instr  <= INSTRUCTION_WIDTH'(word);
                    fifo_count <= 2'd1;
                end
                2'd1: begin
                    if (push && pop) begin
                        out_instr <= INSTRUCTION_WIDTH'(word);
                    end else if (push) begin
                        tail       <= INSTRUCTION_WIDTH'(word);
                        fifo_count <= 2'd2;
                    end else if (pop) begin
                        fifo_count <= 2'd0;
                    end
                end
                default: if (pop) begin
                    // Full: no push possible, so only the pop path matters.
                    out_instr  <= tail;
                    fifo_count <= 2'd1;
                end
            endcase
        end
    end

    // Registered reject pulse and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= accept && !legal;
            if (accept && !legal && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

    // Saturating count of words handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        emit_count <= '0;
        else if (pop && emit_count != '1)  emit_count <= emit_count + 1'b1;
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: encodings, reject path, back-pressure, reset.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [31:0] req_offset;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err_pulse;
    logic [15:0] emit_count;
    logic [15:0] err_count;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int exp_emit = 0;
    int exp_err = 0;

    imm_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_offset(req_offset),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err_pulse(err_pulse), .emit_count(emit_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] off);
        req_valid  = 1'b1;
        req_kind   = k;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_funct3 = f3;
        req_offset = off;
    endtask

    // One request across one rising edge; returns 1 time unit after the edge.
    task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] off);
        @(negedge clk);
        drive(k, rd, rs1, rs2, f3, off);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        req_kind = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_funct3 = '0; req_offset = '0;

        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        chk("rst_emit", 32'(emit_count), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_req_ready", 32'(req_ready), 0);

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(req_ready), 1);

        // LOAD rd=5 rs1=2 f3=2 off=-4
        send(2'd0, 5'd5, 5'd2, 5'd31, 3'd2, -32'sd4);
        chk("load_valid", 32'(out_valid), 1);
        chk("load_instr", out_instr, 32'hFFC12283);
        pop_one(); exp_emit++;
        chk("load_emit", 32'(emit_count), exp_emit);
        chk("load_drained", 32'(out_valid), 0);

        // STORE rs2=6 rs1=1 f3=2 off=8
        send(2'd1, 5'd17, 5'd1, 5'd6, 3'd2, 32'd8);
        chk("store_instr", out_instr, 32'h0060A423);
        pop_one(); exp_emit++;

        // BRANCH rs1=0 rs2=0 f3=0 off=-1
        send(2'd2, 5'd9, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
        chk("branch_instr", out_instr, 32'hFE000FE3);
        pop_one(); exp_emit++;
        chk("branch_emit", 32'(emit_count), exp_emit);

        // Illegal kind
        send(2'd3, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0); exp_err++;
        chk("illegal_pulse", 32'(err_pulse), 1);
        chk("illegal_errcnt", 32'(err_count), exp_err);
        chk("illegal_novalid", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("illegal_pulse_drop", 32'(err_pulse), 0);

        // Offset 2048 on a LOAD rd=1 rs1=1
        send(2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 32'd2048);
`ifdef IMM_ENCODER_RANGE_CHECK_EN
        exp_err++;
        chk("range_pulse", 32'(err_pulse), 1);
        chk("range_errcnt", 32'(err_count), exp_err);
        chk("range_novalid", 32'(out_valid), 0);
`else
        chk("trunc_valid", 32'(out_valid), 1);
        chk("trunc_imm", 32'(out_instr[31:20]), 32'h800);
        chk("trunc_instr", out_instr, 32'h80008083);
        pop_one(); exp_emit++;
`endif
        chk("range_emit", 32'(emit_count), exp_emit);

        // Reject sharing a cycle with a pop
        send(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
        chk("share_pre_instr", out_instr, 32'h00000083);
        @(negedge clk);
        out_ready = 1'b1;
        drive(2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; out_ready = 1'b0;
        exp_emit++; exp_err++;
        chk("share_emit", 32'(emit_count), exp_emit);
        chk("share_pulse", 32'(err_pulse), 1);
        chk("share_errcnt", 32'(err_count), exp_err);
        chk("share_empty", 32'(out_valid), 0);

        // Back-pressure: A and B fill the FIFO, C stalls
        send(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
        send(2'd0, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
        chk("bp_full_ready", 32'(req_ready), 0);
        @(negedge clk);
        drive(2'd0, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3);
        @(posedge clk); #1;
        chk("bp_stall_ready", 32'(req_ready), 0);
        chk("bp_head_a", out_instr, 32'h00100083);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;          // pops A, C still waiting
        exp_emit++;
        chk("bp_head_b", out_instr, 32'h00200103);
        @(posedge clk); #1;          // pops B, accepts C
        req_valid = 1'b0; exp_emit++;
        chk("bp_head_c", out_instr, 32'h00300183);
        chk("bp_c_valid", 32'(out_valid), 1);
        @(posedge clk); #1;          // pops C
        exp_emit++;
        chk("bp_drained", 32'(out_valid), 0);
        chk("bp_emit", 32'(emit_count), exp_emit);
        out_ready = 1'b0;

        // Reset with two entries queued
        send(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
        send(2'd0, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
        chk("mid_full", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_emit", 32'(emit_count), 0);
        chk("mid_rst_err", 32'(err_count), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        @(negedge clk) begin rst_n = 1'b1; out_ready = 1'b1; end
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(req_ready), 1);
        chk("post_rst_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("post_rst_stale", 32'(out_valid), 0);
        chk("post_rst_emit", 32'(emit_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
